grf_multiport: RTL and testbench
================================

# grf_multiport

Parametrised general register file with a configurable number of combinational read ports and synchronous write ports, optional write-to-read bypass, and a per-register pending scoreboard for hazard tracking. It sits in the decode stage of the pipelined CPU. Writeback ports drive writes; the issue logic drives allocations. Each read port reports both the value and whether that value is final.

## Interface
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 5: register index width; depth is 2**ADDR_W.
- `NUM_RD`, default 2: read port count (1..4).
- `NUM_WR`, default 1: write port count (1..2).
- `BYPASS`, default 1: 1 means same-cycle writes are visible on read ports; 0 means reads return stored state only.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `rd_addr`  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W  read data, packed the same way.
- `rd_ready`  out  NUM_RD  1 when the corresponding `rd_data` is final, meaning no pending producer.
- `wr_en`  in  NUM_WR  write enables.
- `wr_addr`  in  NUM_WR*ADDR_W  write addresses.
- `wr_data`  in  NUM_WR*DATA_W  write data.
- `wr_pc`  in  NUM_WR*32  PC of the writing instruction; used for the trace only.
- `alloc_en`  in  1  marks `alloc_addr` as having an in-flight producer.
- `alloc_addr`  in  ADDR_W  register being allocated.

## Operation
- Register 0:
  - Always reads 0 with `rd_ready`=1.
  - Writes and allocations targeting it are ignored, and no trace line is produced.
- Storage write: at posedge, for each port with `wr_en`=1 and a nonzero address, `rf[addr] <= data`.
  - Two ports writing the same address in the same cycle: the higher-index port wins.
  - Only the winning write is traced.
- Trace (simulation only): one line per effective write, `"%d@%h: $%d <= %h"` with `$time`, `wr_pc`, `wr_addr`, `wr_data`. Ports are emitted in ascending index order.
- Pending scoreboard: one bit per register.
  - Set by `alloc_en` at posedge.
  - Cleared by an effective write to that register at posedge.
  - Alloc and write to the same register in the same cycle: the bit ends set, because the new producer supersedes the old one.
- Read port k, combinational:
  - With `BYPASS`=1 and a write this cycle matching `rd_addr` (nonzero): `rd_data` is the winning write's data and `rd_ready`=1.
  - Otherwise: `rd_data` = `rf[rd_addr]` and `rd_ready` = !pending[rd_addr].
  - With `BYPASS`=0: `rd_data` = `rf[rd_addr]` and `rd_ready` = !pending[rd_addr], with no bypass term.
- Reset: at posedge with `reset`=1, all registers clear to 0 and all pending bits clear to 0. Writes and allocs presented in that cycle are discarded and not traced.

## Timing
- Read latency: 0 cycles, combinational from `rd_addr` and state (and from the write ports when `BYPASS`=1).
- Write latency: visible from stored state on the cycle after the edge; with `BYPASS`=1, visible in the same cycle.
- Alloc: `rd_ready` drops starting the cycle after the alloc edge. It is never affected combinationally by `alloc_en`.
- Reset values:
  - After the reset edge, every `rd_data`=0 and every `rd_ready`=1.
  - Before the first reset, outputs are undefined.
- Reset mid-operation: pending producers are forgotten. A later write to a previously pending register is an ordinary write.
- No handshake back-pressure: a write is always accepted.

## Structure
- Shared package `cpu_pkg`:
  - `DATA_W`/`ADDR_W` defaults.
  - `REG_ZERO` constant (0).
  - Trace format string, shared with the DM trace.
- Sub-module `grf_read_port`, instantiated NUM_RD times via generate.
  - Inputs: the address, the full register array view, the pending vector, and the write ports.
  - Outputs: data and ready.
  - Contains the write-priority and bypass selection.
- Top level holds the storage array, the pending vector, the write/alloc update logic and the trace.

## Test plan
- Reset, then read all 32 addresses on both ports -> every `rd_data`=0, `rd_ready`=1.
- Write $5=0xDEADBEEF with pc 0x3000; read $5 the same cycle and the next cycle -> BYPASS=1: 0xDEADBEEF in both cycles. BYPASS=0: old value 0, then 0xDEADBEEF. Exactly one trace line with pc 00003000.
- Write $0=0x12345678 -> $0 still reads 0 and no trace line.
- `NUM_WR`=2, both ports write $7 (port0=0x1, port1=0x2) -> $7=0x2, single trace line for port1.
- Alloc $9 at cycle t -> `rd_ready` for $9 is 0 from t+1. Write $9=0xAA at t+3 -> `rd_ready`=1 in t+3 (bypass) with data 0xAA. Alloc and write $9 in the same cycle -> `rd_ready`=0 next cycle.
- Alloc $4, write $4=0x55, then assert reset the next cycle with a concurrent write $4=0x66 -> after reset $4=0, `rd_ready`=1, no trace for 0x66.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: default datapath widths, the hard-wired zero register
// index, and the writeback trace formatter shared with the data-memory trace.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned CPU_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;

    // One writeback trace line: "<time>@<pc>: $<reg> <= <data>"
    function automatic string trace_line(
        input longint unsigned        t,
        input logic [31:0]            pc,
        input int unsigned            addr,
        input logic [CPU_DATA_W-1:0]  data
    );
        return $sformatf("%d@%h: $%d <= %h", t, pc, addr, data);
    endfunction

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port of the general register file.
// Ports: addr (register index), rf (full register array view), pending
// (per-register in-flight producer bits), wr_en/wr_addr/wr_data (this cycle's
// write ports, used for bypass), data/ready (read result and finality).
module grf_read_port
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
)(
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   rf,
    input  logic [(1<<ADDR_W)-1:0]               pending,
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]             wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]             wr_data,
    output logic [DATA_W-1:0]                    data,
    output logic                                 ready
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    // Stored value first; matching writes override in ascending port order so
    // the highest-index writer wins; register zero overrides everything.
    always_comb begin
        data  = rf[addr];
        ready = ~pending[addr];
        if (BYPASS != 0 && addr != ZERO_ADDR) begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == addr) begin
                    data  = wr_data[i*DATA_W +: DATA_W];
                    ready = 1'b1;
                end
            end
        end
        if (addr == ZERO_ADDR) begin
            data  = '0;
            ready = 1'b1;
        end
    end

endmodule

// File: rtl/grf_multiport.sv
// Multi-port general register file with write bypass and pending scoreboard.
// Ports: clk, reset (sync, active-high); rd_addr/rd_data/rd_ready packed read
// ports; wr_en/wr_addr/wr_data/wr_pc packed write ports (wr_pc for trace);
// alloc_en/alloc_addr mark a register as having an in-flight producer.
module grf_multiport
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1,
    parameter int unsigned BYPASS = 1
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_WR*32-1:0]       wr_pc,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr
);

    localparam int unsigned       DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0][DATA_W-1:0] rf;
    logic [DEPTH-1:0]             pending;
    logic [NUM_WR-1:0]            wr_win;

    // A write is effective if enabled, not to register zero, and not shadowed
    // by a higher-index port writing the same register this cycle.
    always_comb begin
        wr_win = '0;
        for (int i = 0; i < int'(NUM_WR); i++) begin
            wr_win[i] = wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR);
            for (int j = i + 1; j < int'(NUM_WR); j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == wr_addr[i*ADDR_W +: ADDR_W]) begin
                    wr_win[i] = 1'b0;
                end
            end
        end
    end

    // Storage and scoreboard; a same-cycle alloc outranks the clearing write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf      <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (wr_win[i]) begin
                    rf[wr_addr[i*ADDR_W +: ADDR_W]]      <= wr_data[i*DATA_W +: DATA_W];
                    pending[wr_addr[i*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (alloc_en && alloc_addr != ZERO_ADDR) begin
                pending[alloc_addr] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        grf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS)
        ) u_port (
            .addr    (rd_addr[k*ADDR_W +: ADDR_W]),
            .rf      (rf),
            .pending (pending),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[k*DATA_W +: DATA_W]),
            .ready   (rd_ready[k])
        );
    end

`ifndef SYNTHESIS
    // Writeback trace, effective writes only, ascending port order.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_WR); i++) begin
                if (wr_win[i]) begin
                    $display("%s", trace_line($time, wr_pc[i*32 +: 32],
                                              int'(wr_addr[i*ADDR_W +: ADDR_W]),
                                              CPU_DATA_W'(wr_data[i*DATA_W +: DATA_W])));
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// Bench for grf_multiport: a BYPASS=1 and a BYPASS=0 instance (both 2 read,
// 2 write ports) share stimulus; expectations are queued per cycle and
// compared at the falling edge.
module tb_grf_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [63:0] wr_pc;
    logic        alloc_en;
    logic [4:0]  alloc_addr;

    logic [63:0] b_rd_data, n_rd_data;
    logic [1:0]  b_rd_ready, n_rd_ready;

    always #5 clk = ~clk;

    grf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    grf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_ready(n_rd_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr));

    typedef struct {
        string       tag;
        int          dut;    // 0 = bypass instance, 1 = no-bypass instance
        int          port;
        logic [31:0] data;
        logic        ready;
    } exp_t;

    typedef struct {
        string       tag;
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] bd0;
        logic        br0;
        logic [31:0] bd1;
        logic        br1;
        logic [31:0] nd0;
        logic        nr0;
    } vec_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mrf[32];
    logic        mpend[32];

    function automatic vec_t mk(input string tag, input logic rst, input logic [1:0] we,
                                input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ae, input logic [4:0] aa,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] bd0, input logic br0,
                                input logic [31:0] bd1, input logic br1,
                                input logic [31:0] nd0, input logic nr0);
        vec_t v;
        v.tag = tag; v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ae = ae; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
        v.bd0 = bd0; v.br0 = br0; v.bd1 = bd1; v.br1 = br1; v.nd0 = nd0; v.nr0 = nr0;
        return v;
    endfunction

    task automatic push(input string tag, input int dut, input int port,
                        input logic [31:0] d, input logic r);
        exp_t e;
        e.tag = tag; e.dut = dut; e.port = port; e.data = d; e.ready = r;
        exp_q.push_back(e);
    endtask

    task automatic check(input exp_t e);
        logic [31:0] d;
        logic        r;
        d = (e.dut == 0) ? b_rd_data[e.port*32 +: 32] : n_rd_data[e.port*32 +: 32];
        r = (e.dut == 0) ? b_rd_ready[e.port] : n_rd_ready[e.port];
        n_cmp++;
        if (d !== e.data || r !== e.ready) begin
            n_bad++;
            $display("FAIL %s dut%0d port%0d: got data=%h ready=%b, expected data=%h ready=%b",
                     e.tag, e.dut, e.port, d, r, e.data, e.ready);
        end
    endtask

    // Reference model of the architectural state, advanced once per edge.
    task automatic model_commit();
        if (reset) begin
            for (int a = 0; a < 32; a++) begin
                mrf[a]   = '0;
                mpend[a] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && wr_addr[i*5 +: 5] != 5'd0) begin
                    mrf[wr_addr[i*5 +: 5]]   = wr_data[i*32 +: 32];
                    mpend[wr_addr[i*5 +: 5]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 5'd0) mpend[alloc_addr] = 1'b1;
        end
    endtask

    task automatic model_read(input int byp, input logic [4:0] a,
                              output logic [31:0] d, output logic r);
        d = mrf[a];
        r = ~mpend[a];
        if (byp != 0) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && wr_addr[i*5 +: 5] == a) begin
                    d = wr_data[i*32 +: 32];
                    r = 1'b1;
                end
            end
        end
        if (a == 5'd0) begin
            d = '0;
            r = 1'b1;
        end
    endtask

    // Compare queued expectations mid-cycle, then let the edge commit.
    task automatic run_cycle();
        @(negedge clk);
        while (exp_q.size() > 0) check(exp_q.pop_front());
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; wr_pc = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    vec_t vecs[20];

    initial begin
        logic [31:0] d;
        logic        r;
        logic [4:0]  ra;

        vecs[0]  = mk("wr5_same",      0, 2'b01, 5, 32'hDEADBEEF, 0, 0,     0, 0, 5, 0, 32'hDEADBEEF, 1, 0, 1, 0, 1);
        vecs[1]  = mk("wr5_next",      0, 2'b00, 0, 0,            0, 0,     0, 0, 5, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1);
        vecs[2]  = mk("wr0_same",      0, 2'b01, 0, 32'h12345678, 0, 0,     0, 0, 0, 5, 0, 1, 32'hDEADBEEF, 1, 0, 1);
        vecs[3]  = mk("wr0_next",      0, 2'b00, 0, 0,            0, 0,     0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        vecs[4]  = mk("dual7_same",    0, 2'b11, 7, 32'h1,        7, 32'h2, 0, 0, 7, 7, 32'h2, 1, 32'h2, 1, 0, 1);
        vecs[5]  = mk("dual7_next",    0, 2'b00, 0, 0,            0, 0,     0, 0, 7, 5, 32'h2, 1, 32'hDEADBEEF, 1, 32'h2, 1);
        vecs[6]  = mk("alloc9_t",      0, 2'b00, 0, 0,            0, 0,     1, 9, 9, 9, 0, 1, 0, 1, 0, 1);
        vecs[7]  = mk("alloc9_t1",     0, 2'b00, 0, 0,            0, 0,     0, 0, 9, 9, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk("alloc9_t2",     0, 2'b00, 0, 0,            0, 0,     0, 0, 9, 9, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk("wr9_t3",        0, 2'b01, 9, 32'hAA,       0, 0,     0, 0, 9, 9, 32'hAA, 1, 32'hAA, 1, 0, 0);
        vecs[10] = mk("wr9_t4",        0, 2'b00, 0, 0,            0, 0,     0, 0, 9, 9, 32'hAA, 1, 32'hAA, 1, 32'hAA, 1);
        vecs[11] = mk("alloc_wr9",     0, 2'b10, 0, 0,            9, 32'hBB, 1, 9, 9, 9, 32'hBB, 1, 32'hBB, 1, 32'hAA, 1);
        vecs[12] = mk("alloc_wr9_nx",  0, 2'b00, 0, 0,            0, 0,     0, 0, 9, 9, 32'hBB, 0, 32'hBB, 0, 32'hBB, 0);
        vecs[13] = mk("wr9_clear",     0, 2'b10, 0, 0,            9, 32'hCC, 0, 0, 9, 5, 32'hCC, 1, 32'hDEADBEEF, 1, 32'hBB, 0);
        vecs[14] = mk("alloc4",        0, 2'b00, 0, 0,            0, 0,     1, 4, 4, 9, 0, 1, 32'hCC, 1, 0, 1);
        vecs[15] = mk("alloc_wr4",     0, 2'b01, 4, 32'h55,       0, 0,     1, 4, 4, 4, 32'h55, 1, 32'h55, 1, 0, 0);
        vecs[16] = mk("rst_wr4",       1, 2'b01, 4, 32'h66,       0, 0,     0, 0, 5, 9, 32'hDEADBEEF, 1, 32'hCC, 1, 32'hDEADBEEF, 1);
        vecs[17] = mk("post_rst4",     0, 2'b00, 0, 0,            0, 0,     0, 0, 4, 5, 0, 1, 0, 1, 0, 1);
        vecs[18] = mk("post_rst9",     0, 2'b00, 0, 0,            0, 0,     0, 0, 9, 7, 0, 1, 0, 1, 0, 1);
        vecs[19] = mk("post_rst_wr4",  0, 2'b01, 4, 32'h77,       0, 0,     0, 0, 4, 4, 32'h77, 1, 32'h77, 1, 0, 1);

        drive_idle();
        rd_addr = '0;
        reset   = 1'b1;
        @(posedge clk);
        model_commit();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Every address on both ports reads zero and final after reset.
        for (int a = 0; a < 32; a++) begin
            ra = 5'(31 - a);
            rd_addr = {ra, 5'(a)};
            for (int dut = 0; dut < 2; dut++) begin
                push("rst_sweep", dut, 0, 32'h0, 1'b1);
                push("rst_sweep", dut, 1, 32'h0, 1'b1);
            end
            run_cycle();
        end

        // Directed vectors with hand-computed expectations.
        for (int i = 0; i < 20; i++) begin
            reset      = vecs[i].rst;
            wr_en      = vecs[i].we;
            wr_addr    = {vecs[i].wa1, vecs[i].wa0};
            wr_data    = {vecs[i].wd1, vecs[i].wd0};
            wr_pc      = {32'h0000_3004, 32'h0000_3000};
            alloc_en   = vecs[i].ae;
            alloc_addr = vecs[i].aa;
            rd_addr    = {vecs[i].ra1, vecs[i].ra0};
            push(vecs[i].tag, 0, 0, vecs[i].bd0, vecs[i].br0);
            push(vecs[i].tag, 0, 1, vecs[i].bd1, vecs[i].br1);
            push(vecs[i].tag, 1, 0, vecs[i].nd0, vecs[i].nr0);
            run_cycle();
        end
        drive_idle();

        // Random traffic on a small address window to force collisions.
        for (int n = 0; n < 300; n++) begin
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data    = {$urandom, $urandom};
            wr_pc      = {32'($urandom), 32'($urandom)};
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 7));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            for (int dut = 0; dut < 2; dut++) begin
                for (int p = 0; p < 2; p++) begin
                    model_read((dut == 0) ? 1 : 0, rd_addr[p*5 +: 5], d, r);
                    push("random", dut, p, d, r);
                end
            end
            run_cycle();
        end
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
